// File: rtl/cache_controller_pkg.sv
// Shared definitions for the direct-mapped write-through cache controller:
// default geometry, FSM encoding and the byte-lane merge helper.
package cache_controller_pkg;

    localparam int ADDR_SIZE_DEF  = 16;
    localparam int WORD_SIZE_DEF  = 32;
    localparam int INDEX_BITS_DEF = 6;
    localparam int TAG_BITS       = ADDR_SIZE_DEF - INDEX_BITS_DEF;
    localparam int BVAL_BITS      = 4;
    localparam int LANE_BITS      = WORD_SIZE_DEF / BVAL_BITS;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOOKUP = 3'd1,
        ST_MEM_RD = 3'd2,
        ST_MEM_WR = 3'd3,
        ST_ACK    = 3'd4
    } state_e;

    // Replace each byte lane whose enable is set with the new word's lane.
    function automatic logic [WORD_SIZE_DEF-1:0] byte_merge(
        input logic [WORD_SIZE_DEF-1:0] old_word,
        input logic [WORD_SIZE_DEF-1:0] new_word,
        input logic [BVAL_BITS-1:0]     bval
    );
        logic [WORD_SIZE_DEF-1:0] merged;
        merged = old_word;
        for (int i = 0; i < BVAL_BITS; i++) begin
            if (bval[i]) begin
                merged[i*LANE_BITS +: LANE_BITS] = new_word[i*LANE_BITS +: LANE_BITS];
            end else begin
                merged[i*LANE_BITS +: LANE_BITS] = old_word[i*LANE_BITS +: LANE_BITS];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/cache_controller_if.sv
// Request-side and memory-side bus of the cache controller; the slave view
// belongs to the controller, the master view to its environment.
interface cache_controller_if
    import cache_controller_pkg::*;
#(
    parameter int ADDR_SIZE = ADDR_SIZE_DEF,
    parameter int WORD_SIZE = WORD_SIZE_DEF
);
    logic [ADDR_SIZE-1:0] cache_addr;
    logic [WORD_SIZE-1:0] cache_wdata;
    logic                 cache_rd;
    logic                 cache_wr;
    logic [3:0]           cache_bval;
    logic [WORD_SIZE-1:0] cache_rdata;
    logic                 cache_ack;
    logic [ADDR_SIZE-1:0] mem_addr;
    logic [WORD_SIZE-1:0] mem_wdata;
    logic [3:0]           mem_bval;
    logic                 mem_rd;
    logic                 mem_wr;
    logic                 mem_ack;
    logic [WORD_SIZE-1:0] mem_rdata;

    modport slave (
        input  cache_addr, cache_wdata, cache_rd, cache_wr, cache_bval,
        output cache_rdata, cache_ack,
        output mem_addr, mem_wdata, mem_bval, mem_rd, mem_wr,
        input  mem_ack, mem_rdata
    );

    modport master (
        output cache_addr, cache_wdata, cache_rd, cache_wr, cache_bval,
        input  cache_rdata, cache_ack,
        input  mem_addr, mem_wdata, mem_bval, mem_rd, mem_wr,
        output mem_ack, mem_rdata
    );

endinterface

// File: rtl/cache_controller_line_array.sv
// One-word-per-line storage: valid bits are reset, tag and data are not.
// Combinational read port, single synchronous write port.
module cache_line_array #(
    parameter int INDEX_BITS = 6,
    parameter int TAG_W      = 10,
    parameter int WORD_SIZE  = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [INDEX_BITS-1:0] rd_index,
    output logic                  rd_valid,
    output logic [TAG_W-1:0]      rd_tag,
    output logic [WORD_SIZE-1:0]  rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_index,
    input  logic [TAG_W-1:0]      wr_tag,
    input  logic [WORD_SIZE-1:0]  wr_data
);
    localparam int LINES = 1 << INDEX_BITS;

    logic [LINES-1:0]     valid_r;
    logic [TAG_W-1:0]     tag_r  [LINES];
    logic [WORD_SIZE-1:0] data_r [LINES];

    // Valid bits: cleared by reset, set by any line write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= '0;
        end else if (wr_en) begin
            valid_r[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage, meaningless until the valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_r[wr_index]  <= wr_tag;
            data_r[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_r[rd_index];
    assign rd_tag   = tag_r[rd_index];
    assign rd_data  = data_r[rd_index];

endmodule

// File: rtl/cache_controller.sv
// Direct-mapped, write-through, no-write-allocate cache controller with
// one-word lines; all bus outputs are registered.
module cache_controller
    import cache_controller_pkg::*;
#(
    parameter int ADDR_SIZE  = ADDR_SIZE_DEF,
    parameter int WORD_SIZE  = WORD_SIZE_DEF,
    parameter int INDEX_BITS = INDEX_BITS_DEF
) (
    input logic              cache_clk,
    input logic              cache_rst_n,
    cache_controller_if.slave bus
);
    localparam int TAG_W = ADDR_SIZE - INDEX_BITS;

    state_e               state_r;
    state_e               state_nxt_s;
    logic [ADDR_SIZE-1:0] addr_r;
    logic [WORD_SIZE-1:0] wdata_r;
    logic [3:0]           bval_r;
    logic                 is_wr_r;
    logic [WORD_SIZE-1:0] rdata_r;
    logic                 ack_r;
    logic                 mem_rd_r;
    logic                 mem_wr_r;
    logic [ADDR_SIZE-1:0] mem_addr_r;
    logic [WORD_SIZE-1:0] mem_wdata_r;
    logic [3:0]           mem_bval_r;

    logic                 line_valid_s;
    logic [TAG_W-1:0]     line_tag_s;
    logic [WORD_SIZE-1:0] line_data_s;
    logic                 hit_s;
    logic                 arr_we_s;
    logic [WORD_SIZE-1:0] arr_wdata_s;
    logic                 req_s;
    logic                 mem_start_s;

    assign req_s       = bus.cache_rd | bus.cache_wr;
    assign hit_s       = line_valid_s && (line_tag_s == addr_r[ADDR_SIZE-1:INDEX_BITS]);
    assign mem_start_s = (state_r == ST_LOOKUP) &&
                         ((state_nxt_s == ST_MEM_RD) || (state_nxt_s == ST_MEM_WR));

    cache_line_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_W      (TAG_W),
        .WORD_SIZE  (WORD_SIZE)
    ) u_lines (
        .clk      (cache_clk),
        .rst_n    (cache_rst_n),
        .rd_index (addr_r[INDEX_BITS-1:0]),
        .rd_valid (line_valid_s),
        .rd_tag   (line_tag_s),
        .rd_data  (line_data_s),
        .wr_en    (arr_we_s),
        .wr_index (addr_r[INDEX_BITS-1:0]),
        .wr_tag   (addr_r[ADDR_SIZE-1:INDEX_BITS]),
        .wr_data  (arr_wdata_s)
    );

    // FSM state register.
    always_ff @(posedge cache_clk or negedge cache_rst_n) begin
        if (!cache_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next state and line-array write strobe.
    always_comb begin
        state_nxt_s = state_r;
        arr_we_s    = 1'b0;
        arr_wdata_s = bus.mem_rdata;
        case (state_r)
            ST_IDLE: begin
                if (req_s) begin
                    state_nxt_s = ST_LOOKUP;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOOKUP: begin
                if (is_wr_r) begin
                    if (bval_r == 4'b0000) begin
                        state_nxt_s = ST_ACK;
                    end else begin
                        state_nxt_s = ST_MEM_WR;
                        // Write-through: a hit merges into the line, a miss leaves it alone.
                        if (hit_s) begin
                            arr_we_s    = 1'b1;
                            arr_wdata_s = byte_merge(line_data_s, wdata_r, bval_r);
                        end else begin
                            arr_we_s    = 1'b0;
                        end
                    end
                end else if (hit_s) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_MEM_RD;
                end
            end
            ST_MEM_RD: begin
                if (bus.mem_ack) begin
                    state_nxt_s = ST_ACK;
                    arr_we_s    = 1'b1;
                    arr_wdata_s = bus.mem_rdata;
                end else begin
                    state_nxt_s = ST_MEM_RD;
                end
            end
            ST_MEM_WR: begin
                if (bus.mem_ack) begin
                    state_nxt_s = ST_ACK;
                end else begin
                    state_nxt_s = ST_MEM_WR;
                end
            end
            ST_ACK:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Request capture; a simultaneous rd and wr is taken as a write.
    always_ff @(posedge cache_clk or negedge cache_rst_n) begin
        if (!cache_rst_n) begin
            addr_r  <= '0;
            wdata_r <= '0;
            bval_r  <= 4'b0000;
            is_wr_r <= 1'b0;
        end else if ((state_r == ST_IDLE) && req_s) begin
            addr_r  <= bus.cache_addr;
            wdata_r <= bus.cache_wdata;
            bval_r  <= bus.cache_bval;
            is_wr_r <= bus.cache_wr;
        end
    end

    // Registered bus outputs, derived from the state being entered.
    always_ff @(posedge cache_clk or negedge cache_rst_n) begin
        if (!cache_rst_n) begin
            ack_r       <= 1'b0;
            rdata_r     <= '0;
            mem_rd_r    <= 1'b0;
            mem_wr_r    <= 1'b0;
            mem_addr_r  <= '0;
            mem_wdata_r <= '0;
            mem_bval_r  <= 4'b0000;
        end else begin
            ack_r    <= (state_nxt_s == ST_ACK);
            mem_rd_r <= (state_nxt_s == ST_MEM_RD);
            mem_wr_r <= (state_nxt_s == ST_MEM_WR);
            if (mem_start_s) begin
                mem_addr_r  <= addr_r;
                mem_wdata_r <= wdata_r;
                mem_bval_r  <= is_wr_r ? bval_r : 4'hF;
            end
            if ((state_r == ST_LOOKUP) && !is_wr_r && hit_s) begin
                rdata_r <= line_data_s;
            end else if ((state_r == ST_MEM_RD) && bus.mem_ack) begin
                rdata_r <= bus.mem_rdata;
            end
        end
    end

    assign bus.cache_ack   = ack_r;
    assign bus.cache_rdata = rdata_r;
    assign bus.mem_rd      = mem_rd_r;
    assign bus.mem_wr      = mem_wr_r;
    assign bus.mem_addr    = mem_addr_r;
    assign bus.mem_wdata   = mem_wdata_r;
    assign bus.mem_bval    = mem_bval_r;

endmodule
